// File: rtl/pc_pkg.sv
// pc_pkg: shared types, default branch-target table and counter width for pc_branch_lut
package pc_pkg;
   localparam int PC_D = 12;
   localparam int BR_CNT_W = 16;
   typedef struct packed {
      logic            rel;
      logic [PC_D-1:0] value;
   } lut_entry_t;
   typedef struct packed {
      logic        rel;
      logic [31:0] value;
   } lut_default_t;
   localparam lut_default_t PC_LUT_DEFAULTS [8] = '{
      '{1'b1, 32'd3},
      '{1'b1, 32'hFFFF_FFFC},
      '{1'b1, 32'd8},
      '{1'b1, 32'hFFFF_FFF3},
      '{1'b0, 32'd5},
      '{1'b0, 32'd5},
      '{1'b0, 32'd300},
      '{1'b0, 32'd400}
   };
   function automatic lut_default_t lut_default(input int i);
      return (i >= 0 && i < 8) ? PC_LUT_DEFAULTS[i[2:0]] : '0;
   endfunction
endpackage

// File: rtl/pc_target_table.sv
// pc_target_table: rewritable branch-target table with reset defaults and combinational read
module pc_target_table
   import pc_pkg::*;
#(
   parameter int D  = PC_D,
   parameter int AW = 3
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [D-1:0]  wr_target,
   input  logic          wr_rel,
   input  logic [AW-1:0] sel,
   output logic          rel,
   output logic [D-1:0]  value
);
   localparam int DEPTH = 2 ** AW;
   logic [D:0] tbl      [DEPTH];
   logic [D:0] defaults [DEPTH];
   for (genvar g = 0; g < DEPTH; g++) begin : g_def
      localparam lut_default_t DE = lut_default(g);
      assign defaults[g] = {DE.rel, DE.value[D-1:0]};
   end
   // entries reload their defaults on reset; writes land regardless of stall
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= defaults[i];
      end else if (wr_en) begin
         tbl[wr_addr] <= {wr_rel, wr_target};
      end
   end
   assign rel   = tbl[sel][D];
   assign value = tbl[sel][D-1:0];
endmodule

// File: rtl/pc_branch_lut.sv
// pc_branch_lut: PC register with table-driven relative/absolute branches; PC_BRANCH_CNT_EN adds a saturating taken-branch counter
module pc_branch_lut
   import pc_pkg::*;
#(
   parameter int             D     = PC_D,
   parameter int             AW    = 3,
   parameter logic [D-1:0]   START = '0
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                stall,
   input  logic                branch_en,
   input  logic [AW-1:0]       sel,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [D-1:0]        wr_target,
   input  logic                wr_rel,
   output logic [D-1:0]        pc,
   output logic                branch_taken,
   output logic [BR_CNT_W-1:0] branch_count
);
   logic         ent_rel;
   logic [D-1:0] ent_val;
   logic [D-1:0] next_pc;
   logic         take;
   pc_target_table #(.D(D), .AW(AW)) u_table (
      .Clk       (Clk),
      .Reset     (Reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_target (wr_target),
      .wr_rel    (wr_rel),
      .sel       (sel),
      .rel       (ent_rel),
      .value     (ent_val)
   );
   // stall beats branch beats sequential step; relative adds wrap at D bits
   always_comb begin
      take    = !stall && branch_en;
      next_pc = stall ? pc : take ? (ent_rel ? pc + ent_val : ent_val) : pc + D'(1);
   end
   // PC register and one-cycle taken pulse
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc           <= START;
         branch_taken <= 1'b0;
      end else begin
         pc           <= next_pc;
         branch_taken <= take;
      end
   end
`ifdef PC_BRANCH_CNT_EN
   logic [BR_CNT_W-1:0] cnt;
   // counts taken branches, sticking at all-ones
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) cnt <= '0;
      else if (take && cnt != '1) cnt <= cnt + 1'b1;
   end
   assign branch_count = cnt;
`else
   assign branch_count = '0;
`endif
endmodule

// File: tb/tb_pc_branch_lut.sv
// tb_pc_branch_lut: directed test of pc_branch_lut against an integer model of the next-PC rules
module tb_pc_branch_lut;
   localparam int D  = 12;
   localparam int AW = 3;
   localparam int M  = 2 ** D;
   localparam int DEF_V [8] = '{3, -4, 8, -13, 5, 5, 300, 400};
   localparam bit DEF_R [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
   logic          clk = 0;
   logic          rst = 1;
   logic          stall = 0, branch_en = 0, wr_en = 0, wr_rel = 0;
   logic [AW-1:0] sel = '0, wr_addr = '0;
   logic [D-1:0]  wr_target = '0;
   logic [D-1:0]  pc;
   logic          branch_taken;
   logic [15:0]   branch_count;
   int            tests = 0, fails = 0;
   int            m_pc = 0, m_cnt = 0;
   bit            m_bt = 0;
   int            m_val [8];
   bit            m_rel [8];

   pc_branch_lut #(.D(D), .AW(AW), .START('0)) dut (
      .Clk          (clk),
      .Reset        (rst),
      .stall        (stall),
      .branch_en    (branch_en),
      .sel          (sel),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_target    (wr_target),
      .wr_rel       (wr_rel),
      .pc           (pc),
      .branch_taken (branch_taken),
      .branch_count (branch_count)
   );

   always #5 clk = ~clk;

   function automatic int wrap(input int x);
      return ((x % M) + M) % M;
   endfunction

   // model: apply the priority rules on plain integers, table read before write
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc  <= 0;
         m_bt  <= 0;
         m_cnt <= 0;
         for (int i = 0; i < 8; i++) begin
            m_val[i] <= DEF_V[i];
            m_rel[i] <= DEF_R[i];
         end
      end else begin
         if (stall) begin
            m_bt <= 0;
         end else if (branch_en) begin
            m_pc <= m_rel[sel] ? wrap(m_pc + m_val[sel]) : m_val[sel];
            m_bt <= 1;
`ifdef PC_BRANCH_CNT_EN
            m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
`endif
         end else begin
            m_pc <= wrap(m_pc + 1);
            m_bt <= 0;
         end
         if (wr_en) begin
            m_rel[wr_addr] <= wr_rel;
            m_val[wr_addr] <= wr_rel ? int'($signed(wr_target)) : int'(wr_target);
         end
      end
   end

   // compare DUT to model on every falling edge outside reset
   always @(negedge clk) begin
      if (!rst) begin
         tests++;
         if (int'(pc) != m_pc || branch_taken != m_bt || int'(branch_count) != m_cnt) begin
            fails++;
            $display("FAIL model t=%0t pc=%0h/%0h bt=%0b/%0b cnt=%0d/%0d", $time,
                     pc, m_pc, branch_taken, m_bt, branch_count, m_cnt);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic b, input int sl,
                        input logic we = 0, input int wa = 0, input int wt = 0, input logic wrr = 0);
      stall     = s;
      branch_en = b;
      sel       = AW'(sl);
      wr_en     = we;
      wr_addr   = AW'(wa);
      wr_target = D'(wt);
      wr_rel    = wrr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12 rst = 0;
      chk("reset_pc", int'(pc), 0);
      chk("reset_bt", int'(branch_taken), 0);
      chk("reset_cnt", int'(branch_count), 0);
      for (int i = 1; i <= 10; i++) begin
         drive(0, 0, 0);
         if (i <= 5) chk("free_pc", int'(pc), i);
      end
      chk("free_bt", int'(branch_taken), 0);
      drive(0, 1, 1);
      chk("rel_neg4", int'(pc), 6);
      chk("rel_bt", int'(branch_taken), 1);
      drive(0, 1, 3);
      chk("rel_neg13", int'(pc), 'hFF9);
      drive(0, 1, 0);
      chk("rel_pos3", int'(pc), 'hFFC);
      drive(0, 0, 0);
      chk("bt_pulse_end", int'(branch_taken), 0);
      drive(0, 0, 0);
      drive(0, 0, 0);
      chk("pre_wrap", int'(pc), 'hFFF);
      drive(0, 0, 0);
      chk("wrap", int'(pc), 0);
      drive(0, 1, 6);
      chk("abs300", int'(pc), 300);
      drive(0, 1, 7);
      chk("abs400", int'(pc), 400);
      drive(0, 1, 4);
      chk("abs5", int'(pc), 5);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 2);
         chk("stall_pc", int'(pc), 5);
         chk("stall_bt", int'(branch_taken), 0);
      end
      drive(0, 0, 0);
      chk("unstall", int'(pc), 6);
      while (int'(pc) != 20) drive(0, 0, 0);
      drive(0, 1, 2, 1, 2, 50, 0);
      chk("rbw_old", int'(pc), 28);
      drive(0, 1, 2);
      chk("rbw_new", int'(pc), 50);
      drive(0, 0, 0, 1, 5, 123, 0);
      drive(0, 1, 5, 1, 0, 77, 0);
      chk("pre_reset_pc", int'(pc), 123);
      #3 rst = 1;
      #1;
      chk("async_pc", int'(pc), 0);
      chk("async_bt", int'(branch_taken), 0);
      chk("async_cnt", int'(branch_count), 0);
      #1 rst = 0;
      drive(0, 1, 0);
      chk("default_restored", int'(pc), 3);
`ifdef PC_BRANCH_CNT_EN
      chk("cnt_after", int'(branch_count), 1);
`else
      chk("cnt_tied", int'(branch_count), 0);
`endif
      drive(0, 1, 5);
      chk("entry5_restored", int'(pc), 5);
      drive(0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
